// File: rtl/mult_sequencer.sv
// Shift-add multiplier sequencer: computes a*b on its own datapath, then writes the
// product into the downstream 8-bit accumulator (low byte, then high byte) and
// derives product flags from the accumulator's N/Z.
module mult_sequencer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 prod_zero,
    output logic                 prod_msb,
    output logic                 acc_e0,
    output logic                 acc_e1,
    output logic                 acc_nw,
    output logic [WIDTH-1:0]     acc_data,
    input  logic                 acc_n,
    input  logic                 acc_z
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned PW    = 2 * WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TEST,
        S_ADD,
        S_SHIFT,
        S_WR_LO,
        S_WR_HI,
        S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   m, m_nxt;
    logic [WIDTH-1:0]   q, q_nxt;
    logic [WIDTH-1:0]   p, p_nxt;
    logic               c, c_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               lo_z, lo_z_nxt;
    logic [PW-1:0]      product_nxt;
    logic               prod_zero_nxt, prod_msb_nxt;

    // Output register inputs, decoded from the next state so outputs track the state
    logic               busy_nxt, done_nxt, wr_nxt;
    logic [WIDTH-1:0]   acc_data_nxt;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            m         <= '0;
            q         <= '0;
            p         <= '0;
            c         <= 1'b0;
            cnt       <= '0;
            lo_z      <= 1'b0;
            product   <= '0;
            prod_zero <= 1'b0;
            prod_msb  <= 1'b0;
        end else begin
            state     <= state_nxt;
            m         <= m_nxt;
            q         <= q_nxt;
            p         <= p_nxt;
            c         <= c_nxt;
            cnt       <= cnt_nxt;
            lo_z      <= lo_z_nxt;
            product   <= product_nxt;
            prod_zero <= prod_zero_nxt;
            prod_msb  <= prod_msb_nxt;
        end
    end

    // Next-state and datapath transfer logic
    always_comb begin
        state_nxt     = state;
        m_nxt         = m;
        q_nxt         = q;
        p_nxt         = p;
        c_nxt         = c;
        cnt_nxt       = cnt;
        lo_z_nxt      = lo_z;
        product_nxt   = product;
        prod_zero_nxt = prod_zero;
        prod_msb_nxt  = prod_msb;

        case (state)
            S_IDLE: begin
                if (start) begin
                    m_nxt     = a;
                    q_nxt     = b;
                    p_nxt     = '0;
                    c_nxt     = 1'b0;
                    cnt_nxt   = CNT_W'(WIDTH);
                    state_nxt = S_TEST;
                end
            end
            S_TEST: begin
                state_nxt = q[0] ? S_ADD : S_SHIFT;
            end
            S_ADD: begin
                {c_nxt, p_nxt} = {1'b0, p} + {1'b0, m};
                state_nxt      = S_SHIFT;
            end
            S_SHIFT: begin
                // {c,P,Q} shifted right by one; carry falls into P's msb
                c_nxt     = 1'b0;
                p_nxt     = {c, p[WIDTH-1:1]};
                q_nxt     = {p[0], q[WIDTH-1:1]};
                cnt_nxt   = cnt - CNT_W'(1);
                state_nxt = (cnt == CNT_W'(1)) ? S_WR_LO : S_TEST;
            end
            S_WR_LO: begin
                state_nxt = S_WR_HI;
            end
            S_WR_HI: begin
                // accumulator already holds the low byte here
                lo_z_nxt    = acc_z;
                product_nxt = {p, q};
                state_nxt   = S_DONE;
            end
            S_DONE: begin
                // accumulator now holds the high byte
                prod_zero_nxt = lo_z & acc_z;
                prod_msb_nxt  = acc_n;
                state_nxt     = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        busy_nxt     = (state_nxt != S_IDLE);
        done_nxt     = (state_nxt == S_DONE);
        wr_nxt       = (state_nxt == S_WR_LO) || (state_nxt == S_WR_HI);
        acc_data_nxt = '0;
        if (state_nxt == S_WR_LO) begin
            acc_data_nxt = q_nxt;
        end else if (state_nxt == S_WR_HI) begin
            acc_data_nxt = p_nxt;
        end
    end

    // Moore control outputs, registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            acc_e0   <= 1'b0;
            acc_e1   <= 1'b0;
            acc_nw   <= 1'b1;
            acc_data <= '0;
        end else begin
            busy     <= busy_nxt;
            done     <= done_nxt;
            acc_e0   <= wr_nxt;
            acc_e1   <= wr_nxt;
            acc_nw   <= ~wr_nxt;
            acc_data <= acc_data_nxt;
        end
    end

endmodule
